frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 100 ++++++++++
 tb/tb_frame_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: selects the animation frame, advancing only at the start of vertical sync
// Ports:
//   vgaclk       - 25 MHz pixel clock, the only clock
//   reset_n      - synchronous active-low reset
//   vsync        - active-low vertical sync from the timing controller
//   btn_step     - raw push button, steps one frame in manual mode
//   mode_auto    - raw switch, 1 = auto-advance every HOLD_FRAMES frames
//   frame_sel    - current frame index for the rectangle mux
//   frame_start  - one-cycle pulse in the cycle frame_sel updates
//   step_pending - manual step accepted, waiting for the next vsync
//   auto_active  - synchronized, registered mode_auto
module frame_sequencer #(
  parameter int NUM_FRAMES   = 4,
  parameter int HOLD_FRAMES  = 15,
  parameter int DEBOUNCE_CYC = 50000,
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic          vgaclk,
  input  logic          reset_n,
  input  logic          vsync,
  input  logic          btn_step,
  input  logic          mode_auto,
  output logic [FW-1:0] frame_sel,
  output logic          frame_start,
  output logic          step_pending,
  output logic          auto_active
);
  typedef enum logic [1:0] {MANUAL_IDLE, MANUAL_PEND, AUTO} state_t;
  state_t state;
  logic btn_s1, btn_s2, mode_s1, mode_s2, btn_db, step, vs_q;
  logic [15:0] db_cnt;
  logic [7:0] hold_cnt;
  logic vs_start;
  logic [FW-1:0] next_sel;
  assign vs_start = vs_q & ~vsync;
  assign next_sel = (frame_sel == FW'(NUM_FRAMES - 1)) ? '0 : frame_sel + FW'(1);
  always_ff @(posedge vgaclk) begin
    if (!reset_n) begin
      {btn_s1, btn_s2, mode_s1, mode_s2} <= '0;
      btn_db       <= 1'b0;
      step         <= 1'b0;
      db_cnt       <= '0;
      vs_q         <= 1'b1;
      auto_active  <= 1'b0;
      hold_cnt     <= '0;
      frame_sel    <= '0;
      frame_start  <= 1'b0;
      step_pending <= 1'b0;
      state        <= MANUAL_IDLE;
    end else begin
      {btn_s1, btn_s2} <= {btn_step, btn_s1};
      {mode_s1, mode_s2} <= {mode_auto, mode_s1};
      vs_q <= vsync;
      auto_active <= mode_s2;
      // db_cnt counts consecutive cycles the synchronized level differs from the accepted one
      db_cnt <= (btn_s2 == btn_db || db_cnt == 16'(DEBOUNCE_CYC - 1)) ? '0 : db_cnt + 16'd1;
      btn_db <= (btn_s2 != btn_db && db_cnt == 16'(DEBOUNCE_CYC - 1)) ? btn_s2 : btn_db;
      // step pulses in the same cycle btn_db rises
      step <= btn_s2 & ~btn_db & (db_cnt == 16'(DEBOUNCE_CYC - 1));
      frame_start <= 1'b0;
      // a mode change wins over any advance in the same cycle
      if (mode_s2 != auto_active) begin
        state        <= mode_s2 ? AUTO : MANUAL_IDLE;
        hold_cnt     <= '0;
        step_pending <= 1'b0;
      end else begin
        case (state)
          MANUAL_IDLE: begin
            if (step && vs_start) begin
              frame_sel   <= next_sel;
              frame_start <= 1'b1;
            end else if (step) begin
              state        <= MANUAL_PEND;
              step_pending <= 1'b1;
            end
          end
          MANUAL_PEND: begin
            if (vs_start) begin
              frame_sel    <= next_sel;
              frame_start  <= 1'b1;
              step_pending <= 1'b0;
              state        <= MANUAL_IDLE;
            end
          end
          default: begin
            if (vs_start) begin
              hold_cnt <= (hold_cnt == 8'(HOLD_FRAMES - 1)) ? '0 : hold_cnt + 8'd1;
              if (hold_cnt == 8'(HOLD_FRAMES - 1)) begin
                frame_sel   <= next_sel;
                frame_start <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
  // frame_sel may only move on a vs_start cycle (reset excepted)
  tear_check: assert property (@(posedge vgaclk) (reset_n && !vs_start) |=> (!reset_n || $stable(frame_sel)));
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed stimulus with a frame_start scoreboard for frame_sequencer
module tb_frame_sequencer;
  logic vgaclk = 1'b0;
  logic reset_n, vsync, btn_step, mode_auto;
  logic [1:0] frame_sel;
  logic frame_start, step_pending, auto_active;
  int total = 0;
  int bad = 0;
  int fs_count = 0;
  int exp_q[$];
  frame_sequencer #(.NUM_FRAMES(4), .HOLD_FRAMES(3), .DEBOUNCE_CYC(4)) dut (
    .vgaclk(vgaclk),
    .reset_n(reset_n),
    .vsync(vsync),
    .btn_step(btn_step),
    .mode_auto(mode_auto),
    .frame_sel(frame_sel),
    .frame_start(frame_start),
    .step_pending(step_pending),
    .auto_active(auto_active)
  );
  always #5 vgaclk = ~vgaclk;
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge vgaclk);
    #1;
  endtask
  task automatic vs_pulse();
    vsync = 1'b0;
    tick(3);
    vsync = 1'b1;
    tick(2);
  endtask
  task automatic press(input int n);
    btn_step = 1'b1;
    tick(n);
    btn_step = 1'b0;
    tick(10);
  endtask
  // monitor: every frame_start must match the next expected frame index
  initial begin
    forever begin
      @(negedge vgaclk);
      if (frame_start) begin
        fs_count++;
        if (exp_q.size() == 0) chk("unexpected_frame_start", 1, 0);
        else chk("frame_start_sel", frame_sel, exp_q.pop_front());
      end
    end
  end
  initial begin
    int lat;
    int fs0;
    reset_n = 1'b0;
    vsync = 1'b1;
    btn_step = 1'b0;
    mode_auto = 1'b0;
    tick(3);
    chk("rst_frame_sel", frame_sel, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_step_pending", step_pending, 0);
    chk("rst_auto_active", auto_active, 0);
    reset_n = 1'b1;
    tick(2);
    btn_step = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (step_pending) begin
        lat = i;
        break;
      end
    end
    chk("step_latency", lat, 7);
    tick(3);
    btn_step = 1'b0;
    chk("sel_held_before_vsync", frame_sel, 0);
    tick(10);
    exp_q.push_back(1);
    vs_pulse();
    chk("pending_cleared", step_pending, 0);
    chk("manual_sel_1", frame_sel, 1);
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      tick(2);
    end
    btn_step = 1'b0;
    tick(10);
    chk("bounce_rejected", step_pending, 0);
    press(8);
    chk("first_press_pending", step_pending, 1);
    press(8);
    chk("second_press_merged", step_pending, 1);
    exp_q.push_back(2);
    vs_pulse();
    vs_pulse();
    chk("merge_single_advance", frame_sel, 2);
    press(8);
    chk("pending_before_reset", step_pending, 1);
    reset_n = 1'b0;
    tick(1);
    chk("midrst_frame_sel", frame_sel, 0);
    chk("midrst_frame_start", frame_start, 0);
    chk("midrst_step_pending", step_pending, 0);
    chk("midrst_auto_active", auto_active, 0);
    reset_n = 1'b1;
    tick(2);
    vs_pulse();
    chk("no_advance_after_reset", frame_sel, 0);
    mode_auto = 1'b1;
    tick(4);
    chk("auto_active_set", auto_active, 1);
    fs0 = fs_count;
    for (int k = 1; k <= 12; k++) begin
      if (k % 3 == 0) exp_q.push_back((k / 3) % 4);
      vs_pulse();
    end
    chk("auto_pulse_count", fs_count - fs0, 4);
    chk("auto_wrap_sel", frame_sel, 0);
    vs_pulse();
    vs_pulse();
    mode_auto = 1'b0;
    tick(2);
    vsync = 1'b0;
    tick(3);
    vsync = 1'b1;
    tick(2);
    chk("coincide_sel_held", frame_sel, 0);
    chk("coincide_auto_off", auto_active, 0);
    vs_pulse();
    chk("coincide_idle_no_adv", frame_sel, 0);
    press(8);
    chk("manual_after_auto_pending", step_pending, 1);
    exp_q.push_back(1);
    vs_pulse();
    tick(5);
    chk("final_sel", frame_sel, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
